// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: a multi-cycle sequencer for the MEM stage.
// It takes one load or store from the EX/MEM register and presents it to a
// variable-latency data memory over a req/ready handshake. While the access
// is in flight it stalls the pipeline. It captures load data, and it raises
// a sticky error flag on timeouts and misaligned addresses.
module mem_access_ctrl #(
  parameter int TIMEOUT = 16,  // max REQ cycles without mem_ready (>= 2)
  parameter int CNT_W   = 5    // must hold TIMEOUT-1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] read_data_out,
  output logic        stall_out,
  output logic        mem_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic             access;
  logic             aligned;

  // A request with both controls set is treated as a store.
  assign access  = MemRead_in | MemWrite_in;
  assign aligned = (addr_in[1:0] == 2'b00);

  // Freeze the front of the pipeline from the first IDLE cycle of an access
  // until DONE, when the pipeline is allowed to advance.
  // NOTE: this is deliberately combinational. If it were registered, the
  // first cycle of the access would not stall and the EX/MEM contents would
  // move on before they were captured.
  assign stall_out = ((state == IDLE) && access) || (state == REQ);

  // Sequencer: IDLE -> REQ -> DONE, or IDLE -> DONE for a misaligned address.
  // NOTE: all state uses non-blocking assignments, so every branch sees the
  // values from before the edge. For example, REQ tests the mem_we that was
  // latched in IDLE and not one being updated in the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      counter       <= '0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      read_data_out <= '0;
      mem_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            if (aligned) begin
              mem_req   <= 1'b1;
              mem_we    <= MemWrite_in;
              mem_addr  <= addr_in;
              mem_wdata <= wdata_in;
              counter   <= '0;
              state     <= REQ;
            end else begin
              // No request is issued; the stage completes with an error.
              mem_err       <= 1'b1;
              read_data_out <= '0;
              state         <= DONE;
            end
          end
        end

        REQ: begin
          if (mem_ready) begin
            // When ready arrives in the same cycle as the timeout, the
            // access completes normally.
            if (!mem_we) read_data_out <= mem_rdata;
            mem_req <= 1'b0;
            state   <= DONE;
          end else if (counter == LAST_CNT) begin
            mem_req       <= 1'b0;
            mem_err       <= 1'b1;
            read_data_out <= '0;
            state         <= DONE;
          end else begin
            counter <= counter + 1'b1;
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Multi-cycle data-memory sequencer for the MEM stage. It sits between the EX/MEM pipeline register outputs and a variable-latency data memory that uses a req/ready handshake. It stalls the pipeline while an access is in flight, captures read data, and flags failed accesses. Failed accesses are timeouts or misaligned addresses.

Parameters:
TIMEOUT, 16, maximum REQ cycles without mem_ready before the access is abandoned (≥2)
CNT_W, 5, width of the timeout counter (must hold TIMEOUT-1)

Ports:
clk  in  1  pipeline clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
MemRead_in  in  1  EX/MEM MemRead control
MemWrite_in  in  1  EX/MEM MemWrite control
addr_in  in  32  EX/MEM ALU result (byte address)
wdata_in  in  32  EX/MEM store data (reg read data 2)
mem_req  out  1  request valid to data memory
mem_we  out  1  1 = write, 0 = read; valid while mem_req
mem_addr  out  32  word-aligned address; valid while mem_req
mem_wdata  out  32  store data; valid while mem_req and mem_we
mem_ready  in  1  memory completes the current request this cycle
mem_rdata  in  32  read data; valid when mem_ready and !mem_we
read_data_out  out  32  data to MEM/WB; valid in DONE
stall_out  out  1  freeze PC, IF/ID, ID/EX, EX/MEM (combinational)
mem_err  out  1  sticky error flag

Behaviour:
- States: IDLE, REQ, DONE. Reset sets state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, read_data_out=0, mem_err=0, and counter=0.
- Access is defined as access = MemRead_in | MemWrite_in. If both are set, the access is a write.
- stall_out = (state==IDLE & access) | (state==REQ). It is 0 in DONE and 0 in IDLE with no access.
- IDLE with access and addr_in[1:0]==0:
  - Latch mem_addr=addr_in, mem_wdata=wdata_in, mem_we=MemWrite_in.
  - Set counter=0 and go to REQ.
- IDLE with access and addr_in[1:0]!=0:
  - Issue no request; set mem_err=1 and read_data_out=0.
  - Go to DONE.
- IDLE with no access: remain in IDLE. Outputs are unchanged except as stated.
- REQ:
  - mem_req=1. mem_addr, mem_we and mem_wdata are held stable.
  - If mem_ready: on a read, read_data_out<=mem_rdata; on a write, read_data_out is unchanged. Drop mem_req and go to DONE.
  - Else if counter==TIMEOUT-1: drop mem_req, set mem_err=1 and read_data_out=0, and go to DONE.
  - Else counter<=counter+1.
  - If mem_ready arrives in the same cycle as the timeout condition, mem_ready wins: normal completion, no error.
- DONE: mem_req=0 and stall_out=0, so the pipeline advances on this edge. Go unconditionally to IDLE. The next EX/MEM contents are evaluated in IDLE on the following cycle.
- Minimum latency for an aligned access with mem_ready on the first REQ cycle:
  - cycle0 IDLE (stall), cycle1 REQ (stall), cycle2 DONE (advance).
  - Total stall is 2 cycles, plus 1 per extra REQ wait cycle.
- mem_err clears only on reset. It does not block further accesses.
- Reset mid-access: immediate return to IDLE with mem_req=0. Any late mem_ready after reset is ignored.
- mem_ready in IDLE or DONE is ignored.

Test Plan:
- Aligned read: MemRead_in=1, addr_in=0x00000010, mem_ready=1 in the first REQ cycle with mem_rdata=0xDEADBEEF.
  - Required: stall_out=1 for 2 cycles, mem_req=1 for 1 cycle with mem_addr=0x10 and mem_we=0.
  - Required: read_data_out=0xDEADBEEF in DONE, mem_err=0.
- Write with wait states: MemWrite_in=1, addr_in=0x20, wdata_in=0x12345678, mem_ready delayed 3 REQ cycles.
  - Required: mem_req=1, mem_we=1 and mem_wdata=0x12345678 stable for 4 cycles; stall_out=1 for 5 cycles.
  - Required: read_data_out unchanged.
- Timeout: with TIMEOUT=16, issue a read and never assert mem_ready.
  - Required: mem_req high for exactly 16 cycles, then DONE with read_data_out=0 and mem_err=1.
  - Required: a following aligned read with immediate ready completes normally and mem_err stays 1.
- Ready on the timeout boundary: mem_ready=1 on the 16th REQ cycle with mem_rdata=0xA5A5A5A5.
  - Required: read_data_out=0xA5A5A5A5 and mem_err=0.
- Misaligned access and dual control: addr_in=0x22 read.
  - Required: mem_req never asserts, stall_out=1 for 1 cycle, mem_err=1.
  - Then MemRead_in=MemWrite_in=1 at 0x40: required mem_we=1.
- Reset mid-access: assert reset_n=0 during REQ.
  - Required: mem_req=0 and stall_out=0 immediately (asynchronous), all outputs at their reset values.
  - Required: mem_ready pulsed after release is ignored, state stays IDLE.
